// File: rtl/asym_fwft_fifo.sv
// Asymmetric first-word-fall-through FIFO: wide words in, narrow sub-words out.
// Occupancy, almost-full/almost-empty flags and error pulses come from registered pointers only.
module asym_fwft_fifo #(
   parameter int RD_WIDTH   = 8,
   parameter int RATIO      = 4,
   parameter int ADDR_WIDTH = 4,
   parameter int LSB_FIRST  = 1,
   parameter int AF_LEVEL   = (2**ADDR_WIDTH)*RATIO-2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                              clk,
   input  logic                              arst_n,
   input  logic                              wr,
   input  logic [RD_WIDTH*RATIO-1:0]         wr_data,
   output logic                              full,
   output logic                              almost_full,
   output logic                              wr_err,
   input  logic                              rd,
   output logic [RD_WIDTH-1:0]               rd_data,
   output logic                              empty,
   output logic                              almost_empty,
   output logic                              rd_err,
   output logic [ADDR_WIDTH+$clog2(RATIO):0] rd_count
);

   localparam int LOG2R    = $clog2(RATIO);
   localparam int WR_WIDTH = RD_WIDTH*RATIO;
   localparam int DEPTH    = 2**ADDR_WIDTH;
   localparam int CNT_W    = ADDR_WIDTH+LOG2R+1;
   localparam logic [CNT_W-1:0] AF_L = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_L = CNT_W'(AE_LEVEL);

   logic [WR_WIDTH-1:0]   mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [CNT_W-1:0]      rd_ptr;
   logic [ADDR_WIDTH:0]   rd_word;
   logic [LOG2R-1:0]      sub_idx;
   logic [WR_WIDTH-1:0]   head;
   logic [RD_WIDTH-1:0]   subs [RATIO];
   logic                  wr_en;
   logic                  rd_en;

   assign rd_word  = rd_ptr[CNT_W-1:LOG2R];
   assign rd_count = {wr_ptr, {LOG2R{1'b0}}} - rd_ptr;

   assign empty        = (rd_count == '0);
   assign almost_full  = (rd_count >= AF_L);
   assign almost_empty = (rd_count <= AE_L);

   // The head slot stays occupied until its last sub-word is popped.
   assign full = (wr_ptr[ADDR_WIDTH] != rd_word[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_word[ADDR_WIDTH-1:0]);

   assign wr_en = wr & ~full;
   assign rd_en = rd & ~empty;

   always_ff @(posedge clk) begin
      if (arst_n && wr_en)
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         wr_err <= 1'b0;
         rd_err <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + CNT_W'(1);
         wr_err <= wr & full;
         rd_err <= rd & empty;
      end
   end

   assign head = mem[rd_word[ADDR_WIDTH-1:0]];

   for (genvar g = 0; g < RATIO; g++) begin : g_sub
      assign subs[g] = head[g*RD_WIDTH +: RD_WIDTH];
   end

   assign sub_idx = (LSB_FIRST != 0) ? rd_ptr[LOG2R-1:0]
                                     : ~rd_ptr[LOG2R-1:0];
   assign rd_data = subs[sub_idx];

endmodule

// File: tb/tb_asym_fwft_fifo.sv
// Bench for asym_fwft_fifo: directed sequences plus a random run,
// with a queue scoreboard checking both sub-word orders.
module tb_asym_fwft_fifo;

   localparam int RW    = 8;
   localparam int R     = 4;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int CAP   = DEPTH*R;
   localparam int CW    = 7;

   logic          clk = 1'b0;
   logic          arst_n;
   logic          wr;
   logic          rd;
   logic [R*RW-1:0] wr_data;

   logic          full, almost_full, wr_err;
   logic [RW-1:0] rd_data;
   logic          empty, almost_empty, rd_err;
   logic [CW-1:0] rd_count;

   logic          full_m, almost_full_m, wr_err_m;
   logic [RW-1:0] rd_data_m;
   logic          empty_m, almost_empty_m, rd_err_m;
   logic [CW-1:0] rd_count_m;

   asym_fwft_fifo #(
      .RD_WIDTH(RW), .RATIO(R), .ADDR_WIDTH(AW), .LSB_FIRST(1)
   ) u_lsb (
      .clk(clk), .arst_n(arst_n),
      .wr(wr), .wr_data(wr_data),
      .full(full), .almost_full(almost_full), .wr_err(wr_err),
      .rd(rd), .rd_data(rd_data),
      .empty(empty), .almost_empty(almost_empty), .rd_err(rd_err),
      .rd_count(rd_count)
   );

   asym_fwft_fifo #(
      .RD_WIDTH(RW), .RATIO(R), .ADDR_WIDTH(AW), .LSB_FIRST(0)
   ) u_msb (
      .clk(clk), .arst_n(arst_n),
      .wr(wr), .wr_data(wr_data),
      .full(full_m), .almost_full(almost_full_m), .wr_err(wr_err_m),
      .rd(rd), .rd_data(rd_data_m),
      .empty(empty_m), .almost_empty(almost_empty_m), .rd_err(rd_err_m),
      .rd_count(rd_count_m)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: accepted writes push expected sub-words, accepted reads pop.
   logic [RW-1:0] q_l[$];
   logic [RW-1:0] q_m[$];
   int            cnt = 0;
   logic          e_wr_err = 1'b0;
   logic          e_rd_err = 1'b0;
   logic          w_ok, r_ok;

   always @(posedge clk) begin
      if (!arst_n) begin
         q_l.delete();
         q_m.delete();
         cnt = 0;
         e_wr_err = 1'b0;
         e_rd_err = 1'b0;
      end else begin
         w_ok = wr && ((cnt+R-1)/R != DEPTH);
         r_ok = rd && (cnt != 0);
         e_wr_err = wr && !w_ok;
         e_rd_err = rd && !r_ok;
         if (r_ok) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
            cnt = cnt - 1;
         end
         if (w_ok) begin
            for (int i = 0; i < R; i++) begin
               q_l.push_back(wr_data[RW*i +: RW]);
               q_m.push_back(wr_data[RW*(R-1-i) +: RW]);
            end
            cnt = cnt + R;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("rd_count", rd_count, cnt);
      chk("rd_count_msb", rd_count_m, cnt);
      chk("empty", empty, cnt == 0);
      chk("full", full, (cnt+R-1)/R == DEPTH);
      chk("almost_full", almost_full, cnt >= CAP-2);
      chk("almost_empty", almost_empty, cnt <= 2);
      chk("wr_err", wr_err, e_wr_err);
      chk("rd_err", rd_err, e_rd_err);
      if (cnt != 0 && q_l.size() != 0) begin
         chk("rd_data_lsb", rd_data, q_l[0]);
         chk("rd_data_msb", rd_data_m, q_m[0]);
      end
   end

   task automatic cyc(input logic w, input logic [31:0] d, input logic r);
      wr      = w;
      wr_data = d;
      rd      = r;
      @(posedge clk);
      #2;
   endtask

   logic [RW-1:0] seq_l [4];
   logic [RW-1:0] seq_m [4];

   initial begin
      seq_l = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      seq_m = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      arst_n  = 1'b0;
      wr      = 1'b0;
      rd      = 1'b0;
      wr_data = '0;
      repeat (2) @(posedge clk);
      #2;
      arst_n = 1'b1;
      chk("reset_empty", empty, 1'b1);
      chk("reset_count", rd_count, 0);
      chk("reset_ae", almost_empty, 1'b1);
      chk("reset_full", full, 1'b0);

      // One wide word, both read orders
      cyc(1'b1, 32'hDDCCBBAA, 1'b0);
      chk("t1_empty", empty, 1'b0);
      chk("t1_count", rd_count, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_lsb", rd_data, seq_l[i]);
         chk("t2_msb", rd_data_m, seq_m[i]);
         cyc(1'b0, '0, 1'b1);
      end
      cyc(1'b0, '0, 1'b0);
      chk("t1_empty_end", empty, 1'b1);
      chk("t1_count_end", rd_count, 0);
      chk("t1_ae_end", almost_empty, 1'b1);

      // Fill to full, then overflow and partial drain
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b0);
         if (i == DEPTH-2) begin
            chk("t3_count60", rd_count, 60);
            chk("t3_af60", almost_full, 1'b0);
            chk("t3_full60", full, 1'b0);
         end
      end
      chk("t3_full", full, 1'b1);
      chk("t3_count64", rd_count, 64);
      chk("t3_af", almost_full, 1'b1);
      cyc(1'b1, 32'hFFFFFFFF, 1'b0);
      chk("t3_wr_err", wr_err, 1'b1);
      chk("t3_count_hold", rd_count, 64);
      cyc(1'b0, '0, 1'b0);
      chk("t3_wr_err_clr", wr_err, 1'b0);
      chk("t3_head", rd_data, 8'h00);
      cyc(1'b0, '0, 1'b1);
      chk("t3_full63", full, 1'b1);
      chk("t3_count63", rd_count, 63);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      chk("t3_full61", full, 1'b1);
      chk("t3_af61", almost_full, 1'b0);
      cyc(1'b0, '0, 1'b1);
      chk("t3_full_clr", full, 1'b0);
      chk("t3_count60b", rd_count, 60);

      // Write rejected while the head's last sub-word pops
      cyc(1'b1, 32'h13121110, 1'b0);
      chk("t4_full", full, 1'b1);
      repeat (3) cyc(1'b0, '0, 1'b1);
      chk("t4_count61", rd_count, 61);
      chk("t4_full61", full, 1'b1);
      cyc(1'b1, 32'hA5A5A5A5, 1'b1);
      chk("t4_wr_err", wr_err, 1'b1);
      chk("t4_full_clr", full, 1'b0);
      chk("t4_count60", rd_count, 60);
      cyc(1'b1, 32'h5A5B5C5D, 1'b0);
      chk("t4_full_again", full, 1'b1);
      chk("t4_count64", rd_count, 64);
      chk("t4_wr_err_clr", wr_err, 1'b0);
      repeat (CAP) cyc(1'b0, '0, 1'b1);
      chk("t4_drained", empty, 1'b1);

      // Read on empty together with a write
      cyc(1'b1, 32'h44332211, 1'b1);
      chk("t5_rd_err", rd_err, 1'b1);
      chk("t5_data", rd_data, 8'h11);
      chk("t5_count", rd_count, 4);
      repeat (4) cyc(1'b0, '0, 1'b1);
      chk("t5_rd_err_clr", rd_err, 1'b0);
      chk("t5_empty", empty, 1'b1);

      // Random traffic with a mid-run reset
      for (int i = 0; i < 10000; i++) begin
         int wp;
         wp = ((i % 5000) < 2500) ? 3 : 1;
         if (i == 5000) begin
            arst_n = 1'b0;
            cyc(1'b1, $urandom, 1'b1);
            arst_n = 1'b1;
            chk("t6_rst_empty", empty, 1'b1);
            chk("t6_rst_count", rd_count, 0);
         end
         cyc(($urandom % 4) < wp, $urandom, ($urandom % 4) >= wp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
